// File: rtl/btpipe_pkg.sv
// Shared constants for the block-throttled pipe-out streamer: word width,
// default block size and the word returned on an underrun read.
package btpipe_pkg;
    localparam int                WORD_W              = 32;
    localparam int                DEFAULT_BLOCK_WORDS = 16;
    localparam logic [WORD_W-1:0] UNDERRUN_FILL       = 32'h0;
endpackage

// File: rtl/btpipe_sfifo.sv
// Synchronous circular-buffer FIFO with a registered read port; a read
// request on an empty FIFO leaves the pointers alone and returns UNDERRUN_FILL.
module btpipe_sfifo
    import btpipe_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid_i,
    input  logic [WORD_W-1:0]     wr_data_i,
    output logic                  wr_ready_o,
    input  logic                  rd_req_i,
    output logic [WORD_W-1:0]     rd_data_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic [DEPTH_LOG2:0]   level_next_o
);
    localparam int                DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WORD_W-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [WORD_W-1:0]     rd_data_q, rd_data_d;
    logic                  wr_en, rd_en;

    assign wr_ready_o   = (level_q != FULL_LEVEL);
    assign wr_en        = wr_valid_i && wr_ready_o;
    assign rd_en        = rd_req_i && (level_q != '0);
    assign rd_data_o    = rd_data_q;
    assign level_o      = level_q;
    assign level_next_o = level_d;

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        rd_data_d = rd_data_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        if (rd_en) begin
            rd_ptr_d  = rd_ptr_q + DEPTH_LOG2'(1);
            rd_data_d = mem_q[rd_ptr_q];
        end else if (rd_req_i) begin
            rd_data_d = UNDERRUN_FILL;
        end
        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + (DEPTH_LOG2 + 1)'(1);
            2'b01:   level_d = level_q - (DEPTH_LOG2 + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rd_data_q <= UNDERRUN_FILL;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            rd_data_q <= rd_data_d;
        end
    end

    // NOTE: storage is not reset; zeroed pointers and level make stale words unreachable.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data_i;
    end
endmodule

// File: rtl/btpipe_out_streamer.sv
// Pipe-out streamer: buffers user words and serves them to a block-throttled
// host endpoint. Define BTPIPE_OUT_UNDERRUN_CNT_EN to build the underrun counter.
module btpipe_out_streamer
    import btpipe_pkg::*;
#(
    parameter int BLOCK_WORDS = DEFAULT_BLOCK_WORDS,
    parameter int DEPTH_LOG2  = 6
) (
    input  logic                okClk,
    input  logic                rst,
    input  logic [WORD_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                ep_read,
    input  logic                ep_blockstrobe,
    output logic [WORD_W-1:0]   ep_datain,
    output logic                ep_ready,
    output logic [DEPTH_LOG2:0] level,
    output logic                blk_done,
    output logic [15:0]         underrun_cnt
);
    localparam int                  BLK_W     = $clog2(BLOCK_WORDS);
    localparam logic [BLK_W-1:0]    LAST_WORD = BLK_W'(BLOCK_WORDS - 1);
    localparam logic [DEPTH_LOG2:0] BLK_LEVEL = (DEPTH_LOG2 + 1)'(BLOCK_WORDS);

    logic [DEPTH_LOG2:0] level_next;
    logic [BLK_W-1:0]    blk_cnt_q, blk_cnt_d, blk_base;
    logic                blk_done_q, blk_done_d;
    logic                ep_ready_q, ep_ready_d;

    btpipe_sfifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk          (okClk),
        .rst          (rst),
        .wr_valid_i   (in_valid),
        .wr_data_i    (in_data),
        .wr_ready_o   (in_ready),
        .rd_req_i     (ep_read),
        .rd_data_o    (ep_datain),
        .level_o      (level),
        .level_next_o (level_next)
    );

    // A block strobe coinciding with a read restarts the block with that read as word 0.
    always_comb begin
        blk_base   = ep_blockstrobe ? '0 : blk_cnt_q;
        blk_cnt_d  = blk_base;
        blk_done_d = 1'b0;
        ep_ready_d = (level_next >= BLK_LEVEL);
        if (ep_read) begin
            blk_cnt_d  = blk_base + BLK_W'(1);
            blk_done_d = (blk_base == LAST_WORD);
        end
    end

    always_ff @(posedge okClk) begin
        if (rst) begin
            blk_cnt_q  <= '0;
            blk_done_q <= 1'b0;
            ep_ready_q <= 1'b0;
        end else begin
            blk_cnt_q  <= blk_cnt_d;
            blk_done_q <= blk_done_d;
            ep_ready_q <= ep_ready_d;
        end
    end

    assign blk_done = blk_done_q;
    assign ep_ready = ep_ready_q;

`ifdef BTPIPE_OUT_UNDERRUN_CNT_EN
    logic [15:0] underrun_q;
    always_ff @(posedge okClk) begin
        if (rst) begin
            underrun_q <= '0;
        end else if (ep_read && (level == '0) && (underrun_q != 16'hFFFF)) begin
            underrun_q <= underrun_q + 16'd1;
        end
    end
    assign underrun_cnt = underrun_q;
`else
    assign underrun_cnt = 16'h0;
`endif
endmodule

// File: tb/tb_btpipe_out_streamer.sv
// Directed self-checking bench for btpipe_out_streamer (default parameters).
module tb_btpipe_out_streamer;
    logic        okClk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        ep_read;
    logic        ep_blockstrobe;
    logic [31:0] ep_datain;
    logic        ep_ready;
    logic [6:0]  level;
    logic        blk_done;
    logic [15:0] underrun_cnt;

    int checks = 0;
    int errors = 0;

    btpipe_out_streamer dut (
        .okClk          (okClk),
        .rst            (rst),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .ep_read        (ep_read),
        .ep_blockstrobe (ep_blockstrobe),
        .ep_datain      (ep_datain),
        .ep_ready       (ep_ready),
        .level          (level),
        .blk_done       (blk_done),
        .underrun_cnt   (underrun_cnt)
    );

    always #5 okClk = ~okClk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge okClk);
        #1;
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        ep_read = 1'b0;
        ep_blockstrobe = 1'b0;
        in_data = '0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic push(input logic [31:0] w);
        in_valid = 1'b1;
        in_data  = w;
        tick;
        in_valid = 1'b0;
    endtask

    task automatic read_expect(input string tag, input logic [31:0] exp);
        ep_read = 1'b1;
        tick;
        ep_read = 1'b0;
        check(tag, ep_datain, exp);
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] exp_w;
        int accepted, wr_n, rd_n, cyc;
        bit do_wr, do_rd;

        // Reset state, sampled while rst is still high.
        rst = 1'b1;
        in_valid = 1'b0;
        ep_read = 1'b0;
        ep_blockstrobe = 1'b0;
        in_data = '0;
        tick;
        tick;
        check("rst_level", 32'(level), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_ep_ready", 32'(ep_ready), 32'd0);
        check("rst_blk_done", 32'(blk_done), 32'd0);
        check("rst_ep_datain", ep_datain, 32'h0);
        check("rst_underrun", 32'(underrun_cnt), 32'd0);
        rst = 1'b0;

        // ep_ready threshold at one full block.
        for (int i = 1; i <= 15; i++) push(32'(i));
        check("thr_level15", 32'(level), 32'd15);
        check("thr_ep_ready15", 32'(ep_ready), 32'd0);
        push(32'd16);
        check("thr_level16", 32'(level), 32'd16);
        check("thr_ep_ready16", 32'(ep_ready), 32'd1);

        // One block of 16 back-to-back reads.
        ep_blockstrobe = 1'b1;
        tick;
        ep_blockstrobe = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ep_read = 1'b1;
            tick;
            check("blk_data", ep_datain, 32'(i + 1));
            check("blk_done", 32'(blk_done), (i == 15) ? 32'd1 : 32'd0);
        end
        ep_read = 1'b0;
        tick;
        check("blk_done_after", 32'(blk_done), 32'd0);
        check("blk_level", 32'(level), 32'd0);
        check("blk_ep_ready", 32'(ep_ready), 32'd0);

        // Underrun reads on an empty FIFO.
        for (int i = 0; i < 3; i++) begin
            read_expect("underrun_data", 32'h0);
            check("underrun_level", 32'(level), 32'd0);
        end
`ifdef BTPIPE_OUT_UNDERRUN_CNT_EN
        check("underrun_cnt", 32'(underrun_cnt), 32'd3);
`else
        check("underrun_cnt", 32'(underrun_cnt), 32'd0);
`endif

        // Fill to full, then read with a blocked write.
        apply_reset;
        accepted = 0;
        for (int i = 0; i < 70; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h100 + 32'(accepted);
            if (in_ready) accepted++;
            tick;
        end
        in_valid = 1'b0;
        check("full_accepted", 32'(accepted), 32'd64);
        check("full_level", 32'(level), 32'd64);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_ep_ready", 32'(ep_ready), 32'd1);
        ep_read = 1'b1;
        in_valid = 1'b1;
        in_data = 32'hDEAD;
        tick;
        ep_read = 1'b0;
        in_valid = 1'b0;
        check("full_rw_level", 32'(level), 32'd63);
        check("full_rw_data", ep_datain, 32'h100);
        check("full_rw_in_ready", 32'(in_ready), 32'd1);
        push(32'hBEEF);
        check("refill_level", 32'(level), 32'd64);

        // Simultaneous read and write at level 1.
        apply_reset;
        push(32'h11);
        ep_read = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h22;
        tick;
        ep_read = 1'b0;
        in_valid = 1'b0;
        check("lvl1_rw_level", 32'(level), 32'd1);
        check("lvl1_rw_data", ep_datain, 32'h11);
        read_expect("lvl1_second", 32'h22);
        check("lvl1_level0", 32'(level), 32'd0);

        // Random streaming against a queue model.
        apply_reset;
        wr_n = 0;
        rd_n = 0;
        cyc = 0;
        exp_w = '0;
        while (rd_n < 200 && cyc < 5000) begin
            in_valid = (wr_n < 200) && ($urandom_range(0, 3) != 0);
            in_data  = 32'hA000_0000 + 32'(wr_n);
            ep_read  = ($urandom_range(0, 1) != 0);
            do_wr = in_valid && (q.size() < 64);
            do_rd = ep_read && (q.size() != 0);
            if (do_rd) exp_w = q.pop_front();
            if (do_wr) begin
                q.push_back(in_data);
                wr_n++;
            end
            tick;
            if (do_rd) begin
                check("stream_data", ep_datain, exp_w);
                rd_n++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        ep_read = 1'b0;
        check("stream_count", 32'(rd_n), 32'd200);
        check("stream_level", 32'(level), 32'd0);

        // Reset in the middle of a block.
        apply_reset;
        for (int i = 0; i < 24; i++) push(32'h200 + 32'(i));
        ep_blockstrobe = 1'b1;
        tick;
        ep_blockstrobe = 1'b0;
        for (int i = 0; i < 8; i++) read_expect("mid_data", 32'h200 + 32'(i));
        check("mid_ep_ready_pre", 32'(ep_ready), 32'd1);
        rst = 1'b1;
        tick;
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_ep_ready", 32'(ep_ready), 32'd0);
        check("mid_rst_blk_cnt", 32'(dut.blk_cnt_q), 32'd0);
        check("mid_rst_ep_datain", ep_datain, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) push(32'h300 + 32'(i));
        for (int i = 0; i < 16; i++) begin
            ep_read = 1'b1;
            ep_blockstrobe = (i == 0);
            tick;
            check("post_rst_data", ep_datain, 32'h300 + 32'(i));
            check("post_rst_blk_done", 32'(blk_done), (i == 15) ? 32'd1 : 32'd0);
        end
        ep_read = 1'b0;
        ep_blockstrobe = 1'b0;
        tick;
        check("post_rst_level", 32'(level), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
